// File: rtl/start_pkg.sv
// ============================================================================
// Module      : start_pkg
// Description : Shared state encoding, widths and helpers for start_debounce.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package start_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PULSE = 2'd1;
   localparam logic [1:0] S_LOCK  = 2'd2;
   localparam logic [1:0] S_HELD  = 2'd3;

   localparam int PULSE_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_PULSE = S_PULSE,
      ST_LOCK  = S_LOCK,
      ST_HELD  = S_HELD
   } state_e;

   // Width able to hold the value n; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_debounce.sv
// ============================================================================
// Module      : sync_debounce
// Description : Two-flop synchroniser plus stable-sample filter for a button.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_debounce
   import start_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic CLK,
   input  logic RST,
   input  logic BTN_IN,
   output logic BTN_LEVEL
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The counter tracks consecutive samples that disagree with the level.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= BTN_IN;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign BTN_LEVEL = level_q;

endmodule

`default_nettype wire

// File: rtl/start_debounce.sv
// ============================================================================
// Module      : start_debounce
// Description : Button conditioner issuing one START strobe per debounced
//               press, with post-pulse lockout. Optional auto-repeat while
//               held is compiled in with START_AUTOREPEAT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module start_debounce
   import start_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int LOCKOUT_CYCLES  = 4,
   parameter int REPEAT_CYCLES   = 1000
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   BTN_IN,
   output logic                   START,
   output logic                   BTN_LEVEL,
   output logic                   BUSY,
   output logic [PULSE_CNT_W-1:0] PULSE_CNT
);

   localparam int LOCK_W = cnt_width(LOCKOUT_CYCLES);
   localparam logic [LOCK_W-1:0] LOCK_LAST =
      LOCK_W'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);

   generate
      if (DEBOUNCE_CYCLES < 1 || LOCKOUT_CYCLES < 0 || REPEAT_CYCLES < 1) begin : g_bad_params
         $error("start_debounce: illegal parameter value");
      end
   endgenerate

   logic                   level;
   state_e                 state_q;
   logic                   start_q;
   logic                   busy_q;
   logic [PULSE_CNT_W-1:0] cnt_q;
   logic [LOCK_W-1:0]      lock_q;

`ifdef START_AUTOREPEAT_EN
   localparam int REP_W = cnt_width(REPEAT_CYCLES);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES);
   logic [REP_W-1:0]       rep_q;
`endif

   sync_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_sync_debounce (
      .CLK       (CLK),
      .RST       (RST),
      .BTN_IN    (BTN_IN),
      .BTN_LEVEL (level)
   );

   // START, BUSY and PULSE_CNT are set on the same edge as the state they mirror.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         lock_q  <= '0;
`ifdef START_AUTOREPEAT_EN
         rep_q   <= '0;
`endif
      end else begin
         start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (level) begin
                  state_q <= ST_PULSE;
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
                  cnt_q   <= cnt_q + PULSE_CNT_W'(1);
               end
            end
            ST_PULSE: begin
               lock_q <= '0;
`ifdef START_AUTOREPEAT_EN
               rep_q  <= '0;
`endif
               if (LOCKOUT_CYCLES > 0) begin
                  state_q <= ST_LOCK;
               end else begin
                  state_q <= ST_HELD;
               end
            end
            ST_LOCK: begin
               if (lock_q == LOCK_LAST) begin
`ifdef START_AUTOREPEAT_EN
                  rep_q <= '0;
`endif
                  if (level) begin
                     state_q <= ST_HELD;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  lock_q <= lock_q + LOCK_W'(1);
               end
            end
            ST_HELD: begin
               if (!level) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
`ifdef START_AUTOREPEAT_EN
               else if (rep_q == REP_LAST) begin
                  state_q <= ST_PULSE;
                  start_q <= 1'b1;
                  cnt_q   <= cnt_q + PULSE_CNT_W'(1);
                  rep_q   <= '0;
               end else begin
                  rep_q <= rep_q + REP_W'(1);
               end
`endif
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign START     = start_q;
   assign BTN_LEVEL = level;
   assign BUSY      = busy_q;
   assign PULSE_CNT = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_start_debounce.sv
// ============================================================================
// Module      : tb_start_debounce
// Description : Directed and randomized bench for start_debounce against a
//               behavioural model of press/lockout/hold timing.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_start_debounce;

   localparam int D = 4;
   localparam int L = 4;
   localparam int R = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn = 1'b0;
   logic       start;
   logic       lvl;
   logic       busy;
   logic [7:0] cnt;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   start_debounce #(
      .DEBOUNCE_CYCLES (D),
      .LOCKOUT_CYCLES  (L),
      .REPEAT_CYCLES   (R)
   ) dut (
      .CLK       (clk),
      .RST       (rst),
      .BTN_IN    (btn),
      .START     (start),
      .BTN_LEVEL (lvl),
      .BUSY      (busy),
      .PULSE_CNT (cnt)
   );

   // Reference model: raw-sample delay line, disagreement run length, and
   // press bookkeeping (armed / lockout cycles left / hold age).
   bit pipe[$];
   bit m_lvl, m_start, m_armed;
   int m_run, m_lock_left, m_age, m_cnt;

   task automatic model_edge(input bit b, input bit r);
      bit lvl_old;
      bit synced;
      bit start_new;
      if (r) begin
         pipe = '{1'b0, 1'b0};
         m_lvl = 0; m_start = 0; m_armed = 1;
         m_run = 0; m_lock_left = 0; m_age = 0; m_cnt = 0;
         return;
      end
      lvl_old = m_lvl;
      synced  = pipe[0];
      if (synced != lvl_old) begin
         m_run++;
         if (m_run == D) begin
            m_lvl = ~m_lvl;
            m_run = 0;
         end
      end else begin
         m_run = 0;
      end
      void'(pipe.pop_front());
      pipe.push_back(b);

      start_new = 0;
      if (m_start) begin
         m_lock_left = L;
         m_age = 0;
      end else if (m_lock_left > 0) begin
         m_lock_left--;
         if (m_lock_left == 0) begin
            m_age = 0;
            if (!lvl_old) m_armed = 1;
         end
      end else if (!m_armed) begin
         if (!lvl_old) begin
            m_armed = 1;
         end else begin
`ifdef START_AUTOREPEAT_EN
            if (m_age == R) begin
               start_new = 1;
               m_age = 0;
            end else begin
               m_age++;
            end
`endif
         end
      end else if (lvl_old) begin
         start_new = 1;
         m_armed = 0;
      end
      m_start = start_new;
      if (start_new) m_cnt = (m_cnt + 1) % 256;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit b, input bit r);
      btn = b;
      rst = r;
      @(posedge clk);
      model_edge(b, r);
      #1;
      check("start", {7'd0, start}, {7'd0, m_start});
      check("level", {7'd0, lvl},   {7'd0, m_lvl});
      check("busy",  {7'd0, busy},  {7'd0, !m_armed});
      check("count", cnt, m_cnt[7:0]);
   endtask

   task automatic press_until_start(output int n);
      n = 0;
      do begin
         step(1'b1, 1'b0);
         n++;
      end while (start !== 1'b1 && n < 60);
   endtask

   initial begin
      int n;
      int extra;
      int exp_extra;
      logic [7:0] c0;

      repeat (3) step(1'b0, 1'b1);
      check("reset_start", {7'd0, start}, 8'd0);
      check("reset_level", {7'd0, lvl},   8'd0);
      check("reset_busy",  {7'd0, busy},  8'd0);
      check("reset_count", cnt,           8'd0);

      // Press latency and single-cycle strobe
      repeat (5) step(1'b0, 1'b0);
      press_until_start(n);
      check("press_latency", n[7:0], 8'(D + 3));
      step(1'b1, 1'b0);
      check("start_width", {7'd0, start}, 8'd0);
      check("first_count", cnt, 8'd1);
      repeat (8) step(1'b1, 1'b0);
      repeat (15) step(1'b0, 1'b0);

      // Bounce shorter than the filter window
      c0 = cnt;
      repeat (5) begin
         repeat (3) step(1'b1, 1'b0);
         step(1'b0, 1'b0);
      end
      check("bounce_no_start", cnt, c0);
      repeat (20) step(1'b1, 1'b0);
      check("bounce_one_start", cnt, c0 + 8'd1);
      repeat (15) step(1'b0, 1'b0);

      // Release glitch and re-press inside lockout
      press_until_start(n);
      c0 = cnt;
      repeat (2) step(1'b0, 1'b0);
      repeat (12) step(1'b1, 1'b0);
      check("lockout_no_repress", cnt, c0);
      repeat (15) step(1'b0, 1'b0);
      press_until_start(n);
      check("fresh_press", cnt, c0 + 8'd1);

      // Reset on the START cycle with the button held
      step(1'b1, 1'b1);
      check("rst_start", {7'd0, start}, 8'd0);
      check("rst_busy",  {7'd0, busy},  8'd0);
      check("rst_count", cnt,           8'd0);
      press_until_start(n);
      check("post_reset_latency", n[7:0], 8'(D + 3));

      // Long hold
      extra = 0;
      for (int i = 0; i < 60; i++) begin
         step(1'b1, 1'b0);
         if (start === 1'b1) extra++;
      end
`ifdef START_AUTOREPEAT_EN
      exp_extra = 60 / (1 + L + R + 1);
`else
      exp_extra = 0;
`endif
      check("hold_repeats", extra[7:0], exp_extra[7:0]);
      repeat (15) step(1'b0, 1'b0);

      // Randomized segments with occasional reset
      for (int s = 0; s < 300; s++) begin
         bit b;
         int len;
         b   = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 12);
         for (int k = 0; k < len; k++) begin
            step(b, ($urandom_range(0, 59) == 0));
         end
      end

      // Counter wrap after 256 presses
      repeat (2) step(1'b0, 1'b1);
      for (int p = 0; p < 256; p++) begin
         repeat (D + 6) step(1'b1, 1'b0);
         repeat (D + 6) step(1'b0, 1'b0);
      end
      check("wrap_count", cnt, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
